// File: rtl/mem_stage.sv
// MEM stage of the multithreaded pipeline. Runs loads and stores over a
// req/gnt/rvalid data-memory handshake. Issues thread-control commands and
// drives the registered MEM/WB outputs that EX forwards from.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned NTRD    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             ins_mem,
  input  logic [31:0]             pc_mem,
  input  logic [31:0]             addr_mem,
  input  logic [31:0]             exe_data_mem,
  input  logic [$clog2(NTRD)-1:0] trd_mem,
  input  logic [4:0]              reg_wr_mem,
  input  logic                    wr_en_mem,
  input  logic                    wb_sel_mem,
  input  logic [1:0]              mem_ctrl_mem,
  input  logic [1:0]              trd_ctrl_mem,
  input  logic [$clog2(NTRD)-1:0] obj_trd_mem,
  input  logic                    stall,
  input  logic                    flushMEM,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [31:0]             dmem_addr,
  output logic [31:0]             dmem_wdata,
  input  logic                    dmem_gnt,
  input  logic                    dmem_rvalid,
  input  logic [31:0]             dmem_rdata,
  output logic                    trd_cmd_valid,
  output logic [1:0]              trd_cmd,
  output logic [$clog2(NTRD)-1:0] trd_cmd_id,
  output logic [$clog2(NTRD)-1:0] trd_cmd_src,
  output logic [31:0]             ins_wb,
  output logic [31:0]             pc_wb,
  output logic [$clog2(NTRD)-1:0] trd_wb,
  output logic [4:0]              reg_wr_wb,
  output logic                    wr_en_wb,
  output logic [31:0]             wb_data_wb,
  output logic                    stall_mem,
  output logic                    bus_err_mem
);

  localparam int unsigned TrdW = $clog2(NTRD);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRdWait,
    StDrain
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            retired_q, retired_d;

  logic [31:0]     ins_wb_q, pc_wb_q, wb_data_wb_q;
  logic [TrdW-1:0] trd_wb_q;
  logic [4:0]      reg_wr_wb_q;
  logic            wr_en_wb_q;

  logic is_load, is_store, need_acc, aligned, misalign, timeout;
  logic req, done, tmo_hit, complete, err, retire, is_cmd;

  // Decode the instruction currently held in MEM.
  always_comb begin
    is_load  = (mem_ctrl_mem == 2'b01);
    is_store = (mem_ctrl_mem == 2'b10);
    need_acc = (is_load | is_store) & ~flushMEM & ~retired_q;
    aligned  = (addr_mem[1:0] == 2'b00);
    misalign = need_acc & ~aligned;
    timeout  = (state_q != StIdle) & (cnt_q == CntW'(TIMEOUT - 1));
    is_cmd   = (trd_ctrl_mem == 2'b01) | (trd_ctrl_mem == 2'b10);
  end

  // Access FSM: next state, request strobe and access-completion flags.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    done    = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        req = need_acc & aligned;
        if (req) begin
          if (!dmem_gnt)    state_d = StReq;
          else if (is_load) state_d = StRdWait;
          else              done    = 1'b1;
        end
      end
      StReq: begin
        req = need_acc & aligned;
        if (!req) begin
          // Flushed (or address moved): drop the request.
          state_d = StIdle;
        end else if (dmem_gnt) begin
          if (is_load) begin
            state_d = StRdWait;
          end else begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end else if (timeout) begin
          tmo_hit = 1'b1;
          state_d = StIdle;
        end
      end
      StRdWait: begin
        if (dmem_rvalid) begin
          // A flush in the same cycle just discards the data.
          done    = need_acc;
          state_d = StIdle;
        end else if (flushMEM) begin
          state_d = StDrain;
        end else if (timeout) begin
          tmo_hit = 1'b1;
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (dmem_rvalid) begin
          state_d = StIdle;
        end else if (timeout) begin
          tmo_hit = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Timeout counter runs while waiting in one state and restarts on any move.
  always_comb begin
    cnt_d = '0;
    if ((state_q != StIdle) && (state_d == state_q)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Retire bookkeeping: a frozen instruction must not retire twice.
  always_comb begin
    err       = misalign | tmo_hit;
    complete  = ~need_acc | misalign | done | tmo_hit;
    retire    = complete & ~retired_q & ~flushMEM & (state_q != StDrain);
    retired_d = stall & (retired_q | retire);
  end

  // State, timeout counter and retired flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      retired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  // MEM/WB register: loads on retire, otherwise holds with a write-enable bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_wb_q     <= '0;
      pc_wb_q      <= '0;
      trd_wb_q     <= '0;
      reg_wr_wb_q  <= '0;
      wb_data_wb_q <= '0;
      wr_en_wb_q   <= 1'b0;
    end else begin
      wr_en_wb_q <= retire & wr_en_mem & (reg_wr_mem != 5'd0) & ~err;
      if (retire) begin
        ins_wb_q     <= ins_mem;
        pc_wb_q      <= pc_mem;
        trd_wb_q     <= trd_mem;
        reg_wr_wb_q  <= reg_wr_mem;
        wb_data_wb_q <= wb_sel_mem ? dmem_rdata : exe_data_mem;
      end
    end
  end

  // Outputs. Combinational strobes are forced low while reset is asserted.
  always_comb begin
    dmem_req      = rst_n & req;
    dmem_we       = mem_ctrl_mem[1];
    dmem_addr     = addr_mem;
    dmem_wdata    = exe_data_mem;
    stall_mem     = rst_n & ((need_acc & aligned & ~complete) | (state_q == StDrain));
    bus_err_mem   = rst_n & err;
    trd_cmd_valid = rst_n & retire & is_cmd;
    trd_cmd       = trd_ctrl_mem;
    trd_cmd_id    = obj_trd_mem;
    trd_cmd_src   = trd_mem;
    ins_wb        = ins_wb_q;
    pc_wb         = pc_wb_q;
    trd_wb        = trd_wb_q;
    reg_wr_wb     = reg_wr_wb_q;
    wr_en_wb      = wr_en_wb_q;
    wb_data_wb    = wb_data_wb_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writebacks, memory
// handshakes and thread commands; a negedge monitor pops and compares them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins_mem, pc_mem, addr_mem, exe_data_mem;
  logic [2:0]  trd_mem, obj_trd_mem;
  logic [4:0]  reg_wr_mem;
  logic        wr_en_mem, wb_sel_mem, stall, flushMEM;
  logic [1:0]  mem_ctrl_mem, trd_ctrl_mem;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        trd_cmd_valid;
  logic [1:0]  trd_cmd;
  logic [2:0]  trd_cmd_id, trd_cmd_src;
  logic [31:0] ins_wb, pc_wb, wb_data_wb;
  logic [2:0]  trd_wb;
  logic [4:0]  reg_wr_wb;
  logic        wr_en_wb, stall_mem, bus_err_mem;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;

  logic [39:0] wb_q[$];   // {trd, reg, data}
  logic [64:0] mem_q[$];  // {we, addr, wdata}
  logic [7:0]  cmd_q[$];  // {cmd, id, src}

  mem_stage #(.TIMEOUT(8), .NTRD(8)) dut (
    .clk(clk), .rst_n(rst_n), .ins_mem(ins_mem), .pc_mem(pc_mem), .addr_mem(addr_mem),
    .exe_data_mem(exe_data_mem), .trd_mem(trd_mem), .reg_wr_mem(reg_wr_mem),
    .wr_en_mem(wr_en_mem), .wb_sel_mem(wb_sel_mem), .mem_ctrl_mem(mem_ctrl_mem),
    .trd_ctrl_mem(trd_ctrl_mem), .obj_trd_mem(obj_trd_mem), .stall(stall),
    .flushMEM(flushMEM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .trd_cmd_valid(trd_cmd_valid), .trd_cmd(trd_cmd),
    .trd_cmd_id(trd_cmd_id), .trd_cmd_src(trd_cmd_src), .ins_wb(ins_wb), .pc_wb(pc_wb),
    .trd_wb(trd_wb), .reg_wr_wb(reg_wr_wb), .wr_en_wb(wr_en_wb), .wb_data_wb(wb_data_wb),
    .stall_mem(stall_mem), .bus_err_mem(bus_err_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ins_mem = 32'h0000_0013; pc_mem = 32'h0; addr_mem = 32'h0; exe_data_mem = 32'h0;
    trd_mem = 3'd0; obj_trd_mem = 3'd0; reg_wr_mem = 5'd0; wr_en_mem = 1'b0;
    wb_sel_mem = 1'b0; mem_ctrl_mem = 2'b00; trd_ctrl_mem = 2'b00;
    stall = 1'b0; flushMEM = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  task automatic set_op(input logic [1:0] mc, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] trd, input logic [4:0] rd, input logic we,
                        input logic sel);
    mem_ctrl_mem = mc; addr_mem = addr; exe_data_mem = data; trd_mem = trd;
    reg_wr_mem = rd; wr_en_mem = we; wb_sel_mem = sel;
    ins_mem = 32'hA5A5_0000 | 32'(rd); pc_mem = 32'h1000 | 32'(rd);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_en_wb) begin
        if (wb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected: got reg=%0d data=%h required no writeback",
                   reg_wr_wb, wb_data_wb);
        end else begin
          logic [39:0] e;
          e = wb_q.pop_front();
          chk("wb_trd", 32'(trd_wb), 32'(e[39:37]));
          chk("wb_reg", 32'(reg_wr_wb), 32'(e[36:32]));
          chk("wb_data", wb_data_wb, e[31:0]);
        end
      end
      if (dmem_req && dmem_gnt) begin
        if (mem_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got addr=%h we=%0d required no handshake",
                   dmem_addr, dmem_we);
        end else begin
          logic [64:0] m;
          m = mem_q.pop_front();
          chk("mem_we", 32'(dmem_we), 32'(m[64]));
          chk("mem_addr", dmem_addr, m[63:32]);
          chk("mem_wdata", dmem_wdata, m[31:0]);
        end
      end
      if (trd_cmd_valid) begin
        if (cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_unexpected: got cmd=%0d id=%0d required no pulse",
                   trd_cmd, trd_cmd_id);
        end else begin
          logic [7:0] c;
          c = cmd_q.pop_front();
          chk("cmd_code", 32'(trd_cmd), 32'(c[7:6]));
          chk("cmd_id", 32'(trd_cmd_id), 32'(c[5:3]));
          chk("cmd_src", 32'(trd_cmd_src), 32'(c[2:0]));
        end
      end
      if (bus_err_mem) err_seen++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(stall_mem), 0);
    chk("rst_wr_en", 32'(wr_en_wb), 0);
    chk("rst_data", wb_data_wb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // ALU op writes back exe data the next cycle.
    set_op(2'b00, 32'h0, 32'h1234, 3'd2, 5'd5, 1'b1, 1'b0);
    wb_q.push_back({3'd2, 5'd5, 32'h1234});
    @(negedge clk); chk("alu_stall", 32'(stall_mem), 0);
    next_cycle();
    idle_inputs();
    @(negedge clk); chk("alu_wr_en", 32'(wr_en_wb), 1);
    next_cycle();

    // Load, gnt in cycle 0, rvalid in cycle 3.
    set_op(2'b01, 32'h100, 32'h0, 3'd3, 5'd7, 1'b1, 1'b1);
    mem_q.push_back({1'b0, 32'h100, 32'h0});
    wb_q.push_back({3'd3, 5'd7, 32'hCAFE_F00D});
    for (int i = 0; i < 4; i++) begin
      dmem_gnt    = (i == 0);
      dmem_rvalid = (i == 3);
      dmem_rdata  = (i == 3) ? 32'hCAFE_F00D : 32'hFFFF_FFFF;
      @(negedge clk);
      chk("ld_stall", 32'(stall_mem), (i < 3) ? 32'd1 : 32'd0);
      chk("ld_req", 32'(dmem_req), (i == 0) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Store under a 4-cycle freeze: one handshake, one writeback.
    set_op(2'b10, 32'h200, 32'hDEAD_BEEF, 3'd4, 5'd9, 1'b1, 1'b0);
    stall = 1'b1; dmem_gnt = 1'b1;
    mem_q.push_back({1'b1, 32'h200, 32'hDEAD_BEEF});
    wb_q.push_back({3'd4, 5'd9, 32'hDEAD_BEEF});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("st_req", 32'(dmem_req), (i == 0) ? 32'd1 : 32'd0);
      chk("st_wr_en", 32'(wr_en_wb), (i == 1) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Misaligned load: no request, error pulse, no writeback.
    set_op(2'b01, 32'h102, 32'h0, 3'd1, 5'd4, 1'b1, 1'b1);
    @(negedge clk);
    chk("mis_req", 32'(dmem_req), 0);
    chk("mis_err", 32'(bus_err_mem), 1);
    next_cycle();
    idle_inputs();
    @(negedge clk); chk("mis_wr_en", 32'(wr_en_wb), 0);
    next_cycle();

    // No grant ever: timeout in cycle 8.
    set_op(2'b01, 32'h300, 32'h0, 3'd5, 5'd6, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("tmo_err", 32'(bus_err_mem), (i == 8) ? 32'd1 : 32'd0);
      chk("tmo_stall", 32'(stall_mem), (i < 8) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("tmo_after_stall", 32'(stall_mem), 0);
    chk("tmo_wr_en", 32'(wr_en_wb), 0);
    next_cycle();

    // Thread start command, then the same command flushed.
    set_op(2'b00, 32'h0, 32'h0, 3'd1, 5'd0, 1'b0, 1'b0);
    trd_ctrl_mem = 2'b01; obj_trd_mem = 3'd3;
    cmd_q.push_back({2'b01, 3'd3, 3'd1});
    @(negedge clk); chk("cmd_pulse", 32'(trd_cmd_valid), 1);
    next_cycle();
    flushMEM = 1'b1;
    @(negedge clk); chk("cmd_flushed", 32'(trd_cmd_valid), 0);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Load granted, flushed in RDWAIT, rvalid two cycles later.
    set_op(2'b01, 32'h400, 32'h0, 3'd6, 5'd8, 1'b1, 1'b1);
    dmem_gnt = 1'b1;
    mem_q.push_back({1'b0, 32'h400, 32'h0});
    next_cycle();
    dmem_gnt = 1'b0; flushMEM = 1'b1;
    next_cycle();
    @(negedge clk); chk("drain_stall0", 32'(stall_mem), 1);
    next_cycle();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    @(negedge clk); chk("drain_stall1", 32'(stall_mem), 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("drain_done", 32'(stall_mem), 0);
    chk("drain_wr_en", 32'(wr_en_wb), 0);
    next_cycle();

    // Reset asserted while in REQ.
    set_op(2'b01, 32'h500, 32'h0, 3'd7, 5'd3, 1'b1, 1'b1);
    next_cycle();
    @(negedge clk); chk("req_before_rst", 32'(dmem_req), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(dmem_req), 0);
    chk("rst_mid_stall", 32'(stall_mem), 0);
    chk("rst_mid_ins", ins_wb, 0);
    chk("rst_mid_pc", pc_wb, 0);
    chk("rst_mid_trd", 32'(trd_wb), 0);
    chk("rst_mid_reg", 32'(reg_wr_wb), 0);
    chk("rst_mid_data", wb_data_wb, 0);
    idle_inputs();
    next_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    @(negedge clk); chk("late_rvalid_stall", 32'(stall_mem), 0);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();

    chk("wb_q_left", 32'(wb_q.size()), 0);
    chk("mem_q_left", 32'(mem_q.size()), 0);
    chk("cmd_q_left", 32'(cmd_q.size()), 0);
    chk("bus_err_count", 32'(err_seen), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the multithreaded pipeline. It consumes the EX/MEM pipeline register (addr, data, control, thread id) and performs loads and stores over a variable-latency req/gnt/rvalid data-memory handshake.
- It issues thread-control commands to the thread manager.
- It produces the registered MEM/WB outputs (trd_wb, reg_wr_wb, wr_en_wb, wb_data_wb) that EX forwards from.
- It raises stall_mem to the hazard unit while an access is outstanding.

Parameters:
- TIMEOUT, 255: cycles to wait in REQ or RDWAIT before abandoning the access.
- NTRD, 8: number of hardware threads. Thread ids are log2(NTRD) = 3 bits.

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
ins_mem  in  32  instruction in MEM
pc_mem  in  32  PC of that instruction
addr_mem  in  32  effective address (ALU result)
exe_data_mem  in  32  EX result; store data when mem_ctrl_mem=10
trd_mem  in  3  thread id of the instruction
reg_wr_mem  in  5  destination register
wr_en_mem  in  1  register write enable
wb_sel_mem  in  1  1 = write back load data, 0 = exe_data_mem
mem_ctrl_mem  in  2  00 none, 01 load, 10 store, 11 none
trd_ctrl_mem  in  2  00 none, 01 start, 10 kill, 11 none
obj_trd_mem  in  3  target thread of the thread command
stall  in  1  global freeze from hazard unit (EX/MEM register holds)
flushMEM  in  1  squash the instruction in MEM
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  32  request address
dmem_wdata  out  32  write data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data
trd_cmd_valid  out  1  one-cycle thread command pulse
trd_cmd  out  2  trd_ctrl_mem value
trd_cmd_id  out  3  obj_trd_mem
trd_cmd_src  out  3  trd_mem
ins_wb  out  32  registered
pc_wb  out  32  registered
trd_wb  out  3  registered
reg_wr_wb  out  5  registered
wr_en_wb  out  1  registered
wb_data_wb  out  32  registered
stall_mem  out  1  access incomplete, hold pipeline
bus_err_mem  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset: all registered outputs 0, state IDLE, retired=0, timeout count 0. dmem_req, trd_cmd_valid, stall_mem and bus_err_mem are 0. Reset mid-access abandons the access; a later rvalid in IDLE is ignored.
- need_acc = mem_ctrl_mem in {01,10} & !flushMEM & !retired.
- Misalignment: addr_mem[1:0] != 0 with need_acc means no request is issued. bus_err_mem pulses, and the instruction retires with wr_en_wb=0.
- Request signals are combinational:
  - dmem_addr = addr_mem.
  - dmem_wdata = exe_data_mem.
  - dmem_we = mem_ctrl_mem[1].
  - All are held stable while dmem_req=1.
- FSM:
  - IDLE: dmem_req = need_acc & aligned.
    - If dmem_gnt: a store completes this cycle; a load goes to RDWAIT.
    - Else go to REQ.
  - REQ: dmem_req=1. On gnt, same completion rules as IDLE.
  - RDWAIT: dmem_req=0. On dmem_rvalid (earliest the cycle after gnt) the load completes this cycle using dmem_rdata, then go to IDLE.
  - DRAIN: entered from RDWAIT when flushMEM=1. Wait for rvalid, discard the data, go to IDLE. stall_mem=1 throughout.
  - Timeout: the counter increments each cycle in REQ/RDWAIT/DRAIN and clears on leaving. When it reaches TIMEOUT: go to IDLE, pulse bus_err_mem, and retire the instruction with wr_en_wb=0.
- complete = the store gnt cycle, the load rvalid cycle, or need_acc=0.
- stall_mem = (need_acc & aligned & !complete) | state==DRAIN.
- Retire, once per instruction:
  - The retire cycle is complete & !retired & !flushMEM & state!=DRAIN.
  - In that cycle the WB registers latch:
    - trd_wb, reg_wr_wb, pc_wb, ins_wb.
    - wr_en_wb = wr_en_mem & (reg_wr_mem != 0).
    - wb_data_wb = wb_sel_mem ? (load data) : exe_data_mem.
  - On every other cycle wr_en_wb is 0 (a bubble) and the other WB registers hold.
  - retired is set if stall=1 in the retire cycle. It clears on any cycle with stall=0.
  - As a result, a frozen instruction neither re-issues its store nor writes back twice.
- Thread command: trd_cmd_valid pulses in the retire cycle when trd_ctrl_mem is 01 or 10.
- flushMEM in IDLE/REQ: the request is dropped (dmem_req=0 that cycle) and a bubble goes to WB.

Test Plan:
- ALU op, exe_data_mem=0x1234, reg 5, wr_en=1, mem_ctrl=00 -> next cycle wr_en_wb=1, reg_wr_wb=5, wb_data_wb=0x1234, stall_mem never 1.
- Load addr 0x100, gnt at cycle 0, rvalid at cycle 3 with rdata 0xCAFEF00D -> stall_mem=1 for cycles 0-2, 0 in cycle 3; wb_data_wb=0xCAFEF00D the cycle after; dmem_req high only in cycle 0.
- Store with stall=1 held for 4 cycles, gnt immediate -> exactly one dmem_req/gnt, one retire, wr_en_wb=1 for one cycle only.
- Load to 0x102 -> no dmem_req, bus_err_mem pulse, wr_en_wb=0. Separately, gnt never asserted with TIMEOUT=8 -> bus_err_mem at cycle 8, stall_mem drops.
- trd_ctrl=01, obj_trd=3, trd_mem=1 -> single trd_cmd_valid pulse with cmd=01, id=3, src=1. Same op with flushMEM=1 -> no pulse.
- Load granted, flushMEM in RDWAIT, rvalid 2 cycles later -> DRAIN, stall_mem=1 until rvalid, no writeback. Separately, rst_n low mid-REQ -> all outputs 0 immediately.
